// File: rtl/ram_burst_reader_if.sv
// Bus bundle for ram_burst_reader: command/status, RAM read port and output stream.
// The reader itself connects through the slave modport; whoever commands bursts,
// models the RAM and consumes the stream sits on the master modport.
interface ram_burst_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  start, base_addr, length, ram_rdata, out_ready,
    output busy, done, ram_addr, ram_we, out_data, out_valid, out_last
  );

  modport master (
    output start, base_addr, length, ram_rdata, out_ready,
    input  busy, done, ram_addr, ram_we, out_data, out_valid, out_last
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read engine in front of a synchronous-read RAM. Issues consecutive
// addresses (wrapping at the RAM depth), tracks reads in a two-stage tag pipe
// matching the RAM's registered-read latency, and buffers returned words in a
// small FIFO that feeds a valid/ready stream with a last-word flag.
module ram_burst_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  ram_burst_reader_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] MAX_LEN  = (ADDR_W + 1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic              tag1_v_q, tag1_v_d;
  logic              tag1_last_q, tag1_last_d;
  logic              tag2_v_q, tag2_v_d;
  logic              tag2_last_q, tag2_last_d;

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic              fifo_last_q [FIFO_DEPTH];
  logic              fifo_last_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

  logic [ADDR_W:0]   len_clamped;
  logic [CNT_W-1:0]  inflight;
  logic              can_issue;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W:0]   issue_rem;
  logic              push;
  logic              pop;
  logic              out_valid;
  logic              out_last;

  // Requests longer than the RAM are cut to one full pass around it.
  assign len_clamped = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;

  // Credit check uses only registered occupancy, so a same-cycle pop never
  // lets a fifth word be in flight.
  assign inflight  = CNT_W'(tag1_v_q) + CNT_W'(tag2_v_q);
  assign can_issue = (fifo_count_q + inflight) <= ISSUE_LIMIT;

  assign push      = tag2_v_q;
  assign out_valid = (fifo_count_q != '0);
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign pop       = out_valid & bus.out_ready;

  assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;

  // Burst control: the first read goes out on the start edge itself so the
  // first word lands three cycles after the start cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    issue       = 1'b0;
    issue_addr  = addr_q;
    issue_rem   = remaining_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (len_clamped == '0) begin
            state_d = DONE;
          end else begin
            issue      = 1'b1;
            issue_addr = bus.base_addr;
            issue_rem  = len_clamped;
            state_d    = (len_clamped == ONE_WORD) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (can_issue) begin
          issue = 1'b1;
          if (remaining_q == ONE_WORD) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      ram_addr_d  = issue_addr;
      addr_d      = issue_addr + ADDR_W'(1);
      remaining_d = issue_rem - ONE_WORD;
    end

    tag1_v_d    = issue;
    tag1_last_d = issue && (issue_rem == ONE_WORD);
    tag2_v_d    = tag1_v_q;
    tag2_last_d = tag1_last_q;
  end

  // Output buffer: capture RAM data when a tag reaches stage 2, pop on handshake.
  always_comb begin
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ram_rdata;
      fifo_last_d[wr_ptr_q] = tag2_last_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State, address, tag and buffer registers; reset flushes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      tag1_v_q     <= 1'b0;
      tag1_last_q  <= 1'b0;
      tag2_v_q     <= 1'b0;
      tag2_last_q  <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      tag1_v_q     <= tag1_v_d;
      tag1_last_q  <= tag1_last_d;
      tag2_v_q     <= tag2_v_d;
      tag2_last_q  <= tag2_last_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_count_q <= fifo_count_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
    end
  end

endmodule
